// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for a VGA-style display. A horizontal pixel
//   counter and a vertical line counter walk the full raster (visible area,
//   front porch, sync, back porch). The sync, blank and frame-start flags
//   are decoded from the *next* counter values and registered together with
//   the counters, so every output describes the same raster position in the
//   same cycle.
//
// Ports
//   vga_clk     in   pixel clock, rising edge
//   reset_n     in   asynchronous reset, active low
//   en          in   run enable; low freezes the raster and blanks output
//   DrawX       out  [9:0] horizontal position, 0..H_TOT-1
//   DrawY       out  [9:0] vertical position, 0..V_TOT-1
//   hs          out  horizontal sync, active low
//   vs          out  vertical sync, active low
//   blank       out  1 = visible pixel, 0 = blanked
//   frame_start out  one-cycle pulse on entry to position (0,0)
//   frame_count out  [7:0] completed-frame counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Boundaries as 10-bit constants so every compare is unsigned 10-bit.
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    function automatic logic hsync_level(input logic [9:0] x);
        return !((x >= HS_BEG) && (x < HS_END));
    endfunction

    function automatic logic vsync_level(input logic [9:0] y);
        return !((y >= VS_BEG) && (y < VS_END));
    endfunction

    function automatic logic visible(input logic [9:0] x, input logic [9:0] y);
        return (x < H_VIS_W) && (y < V_VIS_W);
    endfunction

    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    // Next raster position; only committed when en is high.
    always_comb begin
        x_wrap = (DrawX == H_LAST);
        y_wrap = (DrawY == V_LAST);
        x_nxt  = x_wrap ? 10'd0 : DrawX + 10'd1;
        y_nxt  = DrawY;
        if (x_wrap) begin
            y_nxt = y_wrap ? 10'd0 : DrawY + 10'd1;
        end
    end

    // Flags are decoded from the next position so they line up with the
    // counters they are registered alongside. Reset values describe (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else if (en) begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            hs          <= hsync_level(x_nxt);
            vs          <= vsync_level(y_nxt);
            blank       <= visible(x_nxt, y_nxt);
            frame_start <= x_wrap && y_wrap;
            if (x_wrap && y_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end else begin
            // Frozen: position, syncs and frame count hold; picture is blanked.
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; vga_clk is the only clock and reset_n is the only reset.
REQ-002 Parameter H_VIS, default 640, SHALL set the number of visible pixels per line.
REQ-003 Parameter H_FP, default 16, SHALL set the horizontal front porch length in clocks.
REQ-004 Parameter H_SYNC, default 96, SHALL set the hsync pulse length in clocks.
REQ-005 Parameter H_BP, default 48, SHALL set the horizontal back porch length; H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800.
REQ-006 Parameter V_VIS, default 480, SHALL set the number of visible lines per frame.
REQ-007 Parameter V_FP, default 10, SHALL set the vertical front porch length in lines.
REQ-008 Parameter V_SYNC, default 2, SHALL set the vsync pulse length in lines.
REQ-009 Parameter V_BP, default 33, SHALL set the vertical back porch length; V_TOT = 525.
REQ-010 vga_clk  input  1  pixel clock, 25 MHz nominal, all logic on the rising edge.
REQ-011 reset_n  input  1  asynchronous reset, active low.
REQ-012 en  input  1  run enable; when low, the raster freezes.
REQ-013 DrawX  output  10  current horizontal count, 0..H_TOT-1.
REQ-014 DrawY  output  10  current vertical count, 0..V_TOT-1.
REQ-015 hs  output  1  horizontal sync, active low.
REQ-016 vs  output  1  vertical sync, active low.
REQ-017 blank  output  1  display enable; 1 means a visible pixel, 0 means blanked.
REQ-018 frame_start  output  1  single-cycle pulse marking the start of a frame.
REQ-019 frame_count  output  8  count of completed frames.

Function
REQ-020 All outputs SHALL be registered and mutually coherent: hs, vs, blank and frame_start in a given cycle SHALL describe the DrawX/DrawY present in that same cycle.
REQ-021 When en=1, DrawX SHALL increment by 1 each clock and SHALL wrap from H_TOT-1 to 0.
REQ-022 DrawY SHALL increment only on a DrawX wrap and SHALL wrap from V_TOT-1 to 0 when DrawX also wraps.
REQ-023 hs SHALL be 0 exactly when H_VIS+H_FP <= DrawX < H_VIS+H_FP+H_SYNC (656..751 with defaults), and 1 otherwise.
REQ-024 vs SHALL be 0 exactly when V_VIS+V_FP <= DrawY < V_VIS+V_FP+V_SYNC (490..491 with defaults), and 1 otherwise.
REQ-025 blank SHALL be 1 exactly when DrawX < H_VIS and DrawY < V_VIS; when en=0, blank SHALL be forced to 0.
REQ-026 frame_start SHALL be 1 for exactly the one cycle in which the raster advances into (0,0), i.e. the cycle after (H_TOT-1, V_TOT-1) with en=1; it SHALL be 0 at all other times, including while frozen at (0,0).
REQ-027 frame_count SHALL increment by 1 on the same edge that raises frame_start and SHALL wrap from 255 to 0.
REQ-028 When en=0, DrawX, DrawY, hs, vs and frame_count SHALL hold their values and frame_start SHALL be 0.
REQ-029 When en rises again, counting SHALL resume from the held position with no skipped or repeated count.
REQ-030 Counter width arithmetic SHALL be unsigned 10-bit, and no count value >= H_TOT or >= V_TOT SHALL ever appear on DrawX or DrawY.

Reset
REQ-031 While reset_n=0, the block SHALL hold DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0 and frame_count=0, asynchronously to vga_clk.
REQ-032 The first rising edge after reset_n deasserts with en=1 SHALL produce DrawX=1 and DrawY=0.
REQ-033 Asserting reset_n low mid-frame SHALL immediately return every output to its reset value.

Verification
REQ-034 Scenario: reset, then en=1 for 800 clocks -> DrawX goes 0..799 then returns to 0, DrawY reads 1, hs is low for exactly 96 clocks starting at DrawX=656, and blank=1 for DrawX 0..639 only.
REQ-035 Scenario: en=1 for 420000 clocks -> frame_start pulses exactly once per 420000 clocks, frame_count reads 1, vs is low for exactly 1600 clocks starting at DrawY=490 and DrawX=0.
REQ-036 Scenario: drop en at (700,100) for 50 clocks -> DrawX/DrawY stay at (700,100), blank=0, and the next enabled edge gives (701,100).
REQ-037 Scenario: run 256 frames -> frame_count wraps to 0, and 256 frame_start pulses are counted in total.
REQ-038 Scenario: assert reset_n at (320,240), away from any clock edge -> outputs return to their reset values before the next edge, and the first edge after release gives (1,0).
REQ-039 Scenario: every cycle of a full frame -> a checker confirms hs, vs and blank are consistent with DrawX/DrawY per REQ-023 to REQ-025.
